hilo_mdu: RTL
=============

// Module: hilo_mdu
// PURPOSE
//  E-stage multiply/divide unit owning the HI/LO registers; consumes E_opHILO from the decoder.
//  Executes mult/multu/div/divu with fixed multi-cycle latency.
//  Executes mthi/mtlo as single-cycle writes, and returns HI or LO for mfhi/mflo.
//  Exports start/busy to the hazard unit, which stalls D while an HI/LO-class instr meets start|busy.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (>=1)
//  DIV_LAT   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  E_opHILO   in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo (`HILO_* macros)
//  E_A        in   32  forwarded rs value
//  E_B        in   32  forwarded rt value
//  E_start    out  1   combinational: md op (1-4) accepted this cycle
//  E_busy     out  1   registered: md op in flight
//  E_HILOout  out  32  combinational: HI if op==mfhi, LO if op==mflo, else 0
// BEHAVIOUR
//  Reset values:
//   - HI=LO=0, busy=0, cnt=0, pending result=0; E_start=0 unless op 1-4 present, E_HILOout per mux.
//  Accept rule:
//   - E_start = (E_opHILO in 1..4) & !E_busy.
//   - Md op presented while E_busy=1 is ignored; no restart, no queueing.
//  Start edge:
//   - Result is computed from E_A/E_B and latched into a pending HI/LO pair.
//   - cnt<=LAT (MULT_LAT or DIV_LAT); busy<=1.
//  Countdown:
//   - Each edge with busy=1 does cnt<=cnt-1.
//   - On the edge where cnt==1: HI/LO<=pending, busy<=0.
//   - busy is high for exactly LAT cycles; new HI/LO is visible from cycle T+LAT+1 (T = start cycle).
//   - A new md op may be accepted in that same cycle T+LAT+1.
//  Arithmetic:
//   - mult: signed 32x32->64; multu: unsigned. HI=prod[63:32], LO=prod[31:0].
//   - div: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//   - divu: unsigned quotient/remainder.
//   - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
//   - Divisor==0 (div or divu): op is accepted and busy runs the full DIV_LAT, but HI/LO are left unchanged.
//  mthi/mtlo:
//   - HI (or LO) <= E_A at the edge, only when E_busy=0 & E_start=0.
//   - Otherwise ignored; the hazard unit guarantees this case does not arise.
//  mfhi/mflo:
//   - Reads the architectural HI/LO registers, never the pending pair.
//   - A read during busy returns the old value; the stall prevents it from reaching W.
//  Pipeline flush:
//   - A bubble/flush in E arrives as E_opHILO=0 and has no effect.
//   - An in-flight md op is not cancelled by a flush.
//  Reset mid-operation:
//   - Asserting reset at any time aborts the op immediately: busy=0, cnt=0, HI=LO=0.
//   - The pending result is discarded.
//  Misc:
//   - No X may propagate for any operand: the divide is guarded against a zero divisor.
//   - cnt width = clog2(max(MULT_LAT,DIV_LAT)+1).
// TESTING
//  1. mult: A=0xFFFFFFFD (-3), B=5, cycle T.
//     -> E_start=1 at T; busy=1 for T+1..T+5.
//     -> mfhi at T+6 returns 0xFFFFFFFF; mflo returns 0xFFFFFFF1.
//  2. multu: A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
//  3. div: A=-7, B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     divu: A=7, B=0 -> busy 10 cycles; HI/LO keep prior values.
//  4. Start div; drive mult on the 3rd busy cycle.
//     -> E_start=0; the mult is ignored; the div result commits at the original time.
//  5. mthi A=0x1234, then mflo/mfhi with no busy -> mfhi=0x00001234 next cycle.
//     E_HILOout=0 when op=none.
//  6. Start div; pulse reset asynchronously during the 4th busy cycle (between edges).
//     -> busy=0 immediately; HI=LO=0; no later commit.

Source files
------------

// File: rtl/hilo_mdu_if.sv
// E-stage HI/LO bus between the pipeline (master) and the multiply/divide unit (slave).
interface hilo_mdu_if;
    logic [3:0]  E_opHILO;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_start;
    logic        E_busy;
    logic [31:0] E_HILOout;

    modport master (
        output E_opHILO, E_A, E_B,
        input  E_start, E_busy, E_HILOout
    );

    modport slave (
        input  E_opHILO, E_A, E_B,
        output E_start, E_busy, E_HILOout
    );
endinterface

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div, single-cycle mthi/mtlo,
// combinational mfhi/mflo read of the architectural registers.
module hilo_mdu #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    hilo_mdu_if.slave  bus
);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               md_op_c, start_c, commit_c, is_div_c;

    logic [31:0]        hi, lo;
    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;

    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               signed_div;
    logic [31:0]        dvd_mag, dvs_mag, q_mag, r_mag;

    // Decode of the incoming E-stage operation
    always_comb begin
        md_op_c  = (bus.E_opHILO >= OP_MULT) && (bus.E_opHILO <= OP_DIVU);
        is_div_c = (bus.E_opHILO == OP_DIV) || (bus.E_opHILO == OP_DIVU);
        start_c  = md_op_c && (state == S_IDLE);
    end

    // Arithmetic; divide runs on magnitudes so INT_MIN / -1 and zero divisors stay well-defined
    always_comb begin
        prod_s     = $signed({{32{bus.E_A[31]}}, bus.E_A}) * $signed({{32{bus.E_B[31]}}, bus.E_B});
        prod_u     = {32'd0, bus.E_A} * {32'd0, bus.E_B};
        signed_div = (bus.E_opHILO == OP_DIV);
        dvd_mag    = (signed_div && bus.E_A[31]) ? 32'd0 - bus.E_A : bus.E_A;
        dvs_mag    = (signed_div && bus.E_B[31]) ? 32'd0 - bus.E_B : bus.E_B;
        if (bus.E_B == 32'd0) begin
            dvs_mag = 32'd1;
        end
        q_mag      = dvd_mag / dvs_mag;
        r_mag      = dvd_mag % dvs_mag;

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (bus.E_opHILO)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res_lo = (bus.E_A[31] ^ bus.E_B[31]) ? 32'd0 - q_mag : q_mag;
                res_hi = bus.E_A[31] ? 32'd0 - r_mag : r_mag;
                res_wr = (bus.E_B != 32'd0);
            end
            OP_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
                res_wr = (bus.E_B != 32'd0);
            end
            default: ;
        endcase
    end

    // Busy/countdown control: next state
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (md_op_c) begin
                    state_nx = S_BUSY;
                    cnt_nx   = is_div_c ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            S_BUSY: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = S_IDLE;
                    commit_c = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Busy/countdown control: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // HI/LO and the pending result pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            if (start_c) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end
            if (commit_c) begin
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else if (state == S_IDLE && !start_c) begin
                if (bus.E_opHILO == OP_MTHI) hi <= bus.E_A;
                if (bus.E_opHILO == OP_MTLO) lo <= bus.E_A;
            end
        end
    end

    // Hazard-unit handshake and read mux; reads never see the pending pair
    always_comb begin
        bus.E_start   = start_c;
        bus.E_busy    = (state == S_BUSY);
        bus.E_HILOout = 32'd0;
        if (bus.E_opHILO == OP_MFHI) bus.E_HILOout = hi;
        if (bus.E_opHILO == OP_MFLO) bus.E_HILOout = lo;
        if (bus.E_opHILO == OP_NONE) bus.E_HILOout = 32'd0;
    end
endmodule
